// File: rtl/pc_predict.sv
// Fetch PC generator with a direct-mapped BTB and 2-bit direction counters.
// Produces the instruction-memory address for IF. It accepts trap and
// execute-stage redirects, and it trains the BTB from resolved branches.
module pc_predict #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              BTB_ENTRIES  = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            trap_valid,
    input  logic [XLEN-1:0] trap_vector,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_target,
    input  logic            upd_valid,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcplus4,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target
);

    localparam int IDXW = $clog2(BTB_ENTRIES);
    localparam int TAGW = XLEN - IDXW - 2;

    // Clears the two byte-offset bits so every fetch address is word aligned.
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    // Moves a 2-bit counter one step toward taken or not-taken, holding at 0 and 3.
    function automatic logic [1:0] ctr_step(input logic [1:0] c, input logic taken);
        logic [1:0] r;
        r = c;
        if (taken && c != 2'b11)
            r = c + 2'b01;
        else if (!taken && c != 2'b00)
            r = c - 2'b01;
        return r;
    endfunction

    logic [XLEN-1:0]        pc_q, pc_d;
    logic [BTB_ENTRIES-1:0] valid_q;
    logic [TAGW-1:0]        tag_q [BTB_ENTRIES];
    logic [XLEN-1:0]        tgt_q [BTB_ENTRIES];
    logic [1:0]             ctr_q [BTB_ENTRIES];

    logic [IDXW-1:0] rd_idx, wr_idx;
    logic [TAGW-1:0] rd_tag, wr_tag;
    logic            rd_hit, wr_hit;
    logic            unused_upd_lsb;

    // The BTB ignores the byte offset of the trained PC.
    assign unused_upd_lsb = &{1'b0, upd_pc[1:0]};

    // Read port. Updates land at the clock edge, so the lookup always sees the pre-update entry.
    assign rd_idx      = pc_q[IDXW+1:2];
    assign rd_tag      = pc_q[XLEN-1:IDXW+2];
    assign rd_hit      = valid_q[rd_idx] && (tag_q[rd_idx] == rd_tag);
    assign pred_taken  = rd_hit && ctr_q[rd_idx][1];
    assign pred_target = pred_taken ? tgt_q[rd_idx] : '0;

    assign pc      = pc_q;
    assign pcplus4 = pc_q + XLEN'(4);

    // Training port.
    assign wr_idx = upd_pc[IDXW+1:2];
    assign wr_tag = upd_pc[XLEN-1:IDXW+2];
    assign wr_hit = valid_q[wr_idx] && (tag_q[wr_idx] == wr_tag);

    // Next-PC select. The order is trap, redirect, stall, predicted-taken, sequential.
    always_comb begin
        pc_d = pcplus4;
        if (trap_valid)
            pc_d = trap_vector & ALIGN_MASK;
        else if (redirect_valid)
            pc_d = redirect_target & ALIGN_MASK;
        else if (stall)
            pc_d = pc_q;
        else if (pred_taken)
            pc_d = pred_target & ALIGN_MASK;
    end

    // PC register. Reset loads the reset vector immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            pc_q <= RESET_VECTOR;
        else
            pc_q <= pc_d;
    end

    // Valid bits. They are the only BTB state that reset touches.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid_q <= '0;
        else if (upd_valid && !wr_hit && upd_taken)
            valid_q[wr_idx] <= 1'b1;
    end

    // Tag, target and counter storage. A hit trains the entry; a taken miss allocates it.
    always_ff @(posedge clk) begin
        if (upd_valid) begin
            if (wr_hit) begin
                ctr_q[wr_idx] <= ctr_step(ctr_q[wr_idx], upd_taken);
                if (upd_taken)
                    tgt_q[wr_idx] <= upd_target;
            end else if (upd_taken) begin
                tag_q[wr_idx] <= wr_tag;
                tgt_q[wr_idx] <= upd_target;
                ctr_q[wr_idx] <= 2'b10;
            end
        end
    end

endmodule

// File: tb/tb_pc_predict.sv
// Testbench for pc_predict. It runs a vector table, hand-written BTB sequences,
// and randomized traffic checked against a behavioural model.
module tb_pc_predict;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, trap_valid, redirect_valid, upd_valid, upd_taken;
    logic [31:0] trap_vector, redirect_target, upd_pc, upd_target;
    logic [31:0] pc, pcplus4, pred_target;
    logic        pred_taken;

    int checks = 0;
    int errors = 0;

    pc_predict #(
        .XLEN(32),
        .RESET_VECTOR(32'h100),
        .BTB_ENTRIES(16)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .trap_valid(trap_valid), .trap_vector(trap_vector),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target),
        .pc(pc), .pcplus4(pcplus4), .pred_taken(pred_taken), .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        stall;
        logic        trap;
        logic        redir;
        logic [31:0] tv;
        logic [31:0] rt;
        logic [31:0] exp_pc;
        logic [31:0] exp_p4;
    } vec_t;

    vec_t tbl[11];

    // Behavioural BTB: each slot remembers the full PC it was trained on.
    logic        mv  [16];
    logic [31:0] mpc [16];
    logic [31:0] mtg [16];
    int          mct [16];
    logic [31:0] m_pc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        stall = 0; trap_valid = 0; redirect_valid = 0; upd_valid = 0; upd_taken = 0;
        trap_vector = 0; redirect_target = 0; upd_pc = 0; upd_target = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic [31:0] a);
        redirect_valid = 1; redirect_target = a;
        tick();
        redirect_valid = 0;
        chk("go_pc", pc, a);
    endtask

    task automatic train(input logic [31:0] p, input logic t, input logic [31:0] tg);
        upd_valid = 1; upd_pc = p; upd_taken = t; upd_target = tg;
        tick();
        upd_valid = 0;
    endtask

    function automatic logic [31:0] pool();
        return 32'h100 + 32'(4 * $urandom_range(0, 31));
    endfunction

    initial begin
        logic [31:0] nxt, et;
        logic        ep, hit;
        int          idx, ui;

        tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h104,      32'h108};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h108,      32'h10C};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h10C,      32'h110};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h10C,      32'h110};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,  32'h0,        32'h10C,      32'h110};
        tbl[5]  = '{1'b1, 1'b0, 1'b1, 32'h0,  32'h200,      32'h200,      32'h204};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 32'h80, 32'h300,      32'h80,       32'h84};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'h102,      32'h100,      32'h104};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h83, 32'h0,        32'h80,       32'h84};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 32'h0,  32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0};
        tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,  32'h0,        32'h0,        32'h4};

        idle();
        rst = 1;
        #12;
        chk("rst_pc", pc, 32'h100);
        chk("rst_p4", pcplus4, 32'h104);
        chk("rst_pred", {31'b0, pred_taken}, 32'h0);
        rst = 0;

        // Vector table: sequencing, stall, priority, alignment, wrap.
        for (int i = 0; i < 11; i++) begin
            stall = tbl[i].stall; trap_valid = tbl[i].trap; trap_vector = tbl[i].tv;
            redirect_valid = tbl[i].redir; redirect_target = tbl[i].rt;
            tick();
            chk($sformatf("tbl%0d_pc", i), pc, tbl[i].exp_pc);
            chk($sformatf("tbl%0d_p4", i), pcplus4, tbl[i].exp_p4);
            chk($sformatf("tbl%0d_pred", i), {31'b0, pred_taken}, 32'h0);
        end
        idle();

        // Allocate 0x110 -> 0x300 while redirecting there. The entry is visible the next cycle.
        redirect_valid = 1; redirect_target = 32'h110;
        upd_valid = 1; upd_pc = 32'h110; upd_taken = 1; upd_target = 32'h300;
        tick();
        idle();
        chk("alloc_pc", pc, 32'h110);
        chk("alloc_pred", {31'b0, pred_taken}, 32'h1);
        chk("alloc_tgt", pred_target, 32'h300);
        tick();
        chk("follow_pc", pc, 32'h300);

        // Two not-taken updates drive the counter 2 -> 1 -> 0.
        train(32'h110, 0, 32'h0);
        train(32'h110, 0, 32'h0);
        go(32'h110);
        chk("nt_pred", {31'b0, pred_taken}, 32'h0);
        chk("nt_tgt", pred_target, 32'h0);
        tick();
        chk("nt_seq_pc", pc, 32'h114);

        // Four taken updates saturate the counter at 3; the last one changes the target.
        train(32'h110, 1, 32'h300);
        train(32'h110, 1, 32'h300);
        train(32'h110, 1, 32'h300);
        train(32'h110, 1, 32'h340);
        train(32'h110, 0, 32'h0);
        go(32'h110);
        chk("sat_pred", {31'b0, pred_taken}, 32'h1);
        chk("sat_tgt", pred_target, 32'h340);
        train(32'h110, 0, 32'h0);
        go(32'h110);
        chk("sat_nt2_pred", {31'b0, pred_taken}, 32'h0);

        // An alias on the same index evicts the 0x110 entry.
        train(32'h150, 1, 32'h400);
        go(32'h110);
        chk("alias_miss", {31'b0, pred_taken}, 32'h0);
        go(32'h150);
        chk("alias_hit", {31'b0, pred_taken}, 32'h1);
        chk("alias_tgt", pred_target, 32'h400);

        // A same-cycle update to the current index must not affect this cycle's prediction.
        go(32'h110);
        upd_valid = 1; upd_pc = 32'h110; upd_taken = 1; upd_target = 32'h500;
        #1;
        chk("rbw_pred", {31'b0, pred_taken}, 32'h0);
        tick();
        idle();
        chk("rbw_pc", pc, 32'h114);
        go(32'h110);
        chk("rbw_next_pred", {31'b0, pred_taken}, 32'h1);
        chk("rbw_next_tgt", pred_target, 32'h500);

        // Assert asynchronous reset in the middle of an update.
        upd_valid = 1; upd_pc = 32'h200; upd_taken = 1; upd_target = 32'h600;
        #2 rst = 1;
        #1;
        chk("async_pc", pc, 32'h100);
        upd_valid = 0;
        #2 rst = 0;
        tick();
        chk("post_rst_pc", pc, 32'h104);
        go(32'h110);
        chk("post_rst_110", {31'b0, pred_taken}, 32'h0);
        go(32'h150);
        chk("post_rst_150", {31'b0, pred_taken}, 32'h0);
        go(32'h200);
        chk("post_rst_200", {31'b0, pred_taken}, 32'h0);

        // Randomized traffic against the model, starting from a fresh reset.
        idle();
        #2 rst = 1;
        #3 rst = 0;
        for (int i = 0; i < 16; i++) begin
            mv[i] = 0; mpc[i] = 0; mtg[i] = 0; mct[i] = 0;
        end
        m_pc = 32'h100;
        for (int n = 0; n < 600; n++) begin
            stall = ($urandom % 5) == 0;
            trap_valid = ($urandom % 23) == 0;
            trap_vector = $urandom;
            redirect_valid = ($urandom % 6) == 0;
            redirect_target = pool();
            upd_valid = $urandom % 2;
            upd_pc = pool();
            upd_taken = ($urandom % 3) != 0;
            upd_target = pool() + (($urandom % 8) == 0 ? 32'($urandom % 4) : 32'h0);
            #1;
            idx = int'((m_pc >> 2) & 32'hF);
            hit = mv[idx] && (mpc[idx] == m_pc);
            ep  = hit && (mct[idx] >= 2);
            et  = ep ? mtg[idx] : 32'h0;
            chk("rnd_pc", pc, m_pc);
            chk("rnd_p4", pcplus4, m_pc + 32'd4);
            chk("rnd_pred", {31'b0, pred_taken}, {31'b0, ep});
            chk("rnd_tgt", pred_target, et);
            if (trap_valid)          nxt = trap_vector & ~32'h3;
            else if (redirect_valid) nxt = redirect_target & ~32'h3;
            else if (stall)          nxt = m_pc;
            else if (ep)             nxt = et & ~32'h3;
            else                     nxt = m_pc + 32'd4;
            tick();
            if (upd_valid) begin
                ui = int'((upd_pc >> 2) & 32'hF);
                if (mv[ui] && mpc[ui] == upd_pc) begin
                    if (upd_taken) begin
                        mct[ui] = (mct[ui] < 3) ? mct[ui] + 1 : 3;
                        mtg[ui] = upd_target;
                    end else begin
                        mct[ui] = (mct[ui] > 0) ? mct[ui] - 1 : 0;
                    end
                end else if (upd_taken) begin
                    mv[ui] = 1; mpc[ui] = upd_pc; mtg[ui] = upd_target; mct[ui] = 2;
                end
            end
            m_pc = nxt;
        end
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
